// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory fill arbiter.
//   arb_state_t : arbiter FSM states
//   owner_t     : which cache receives the block being filled
//   MEM_LATENCY : cycles from a read's mem_en to its mem_valid
//   WORDS_PER_BLOCK : words per cache block (power of 2)
package mem_arb_pkg;

  localparam int MEM_LATENCY     = 4;
  localparam int WORDS_PER_BLOCK = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/fill_addr_gen.sv
// Block-fill address generator.
// Holds the block base address plus separate issue (tx) and receive (rx)
// word counters, so reads can be streamed out while earlier responses are
// still arriving.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : latch base from start_addr and clear both counters
//   start_addr   : byte address of the missing word
//   issue        : a read was issued this cycle (advance tx)
//   recv         : a read response was accepted this cycle (advance rx)
//   issue_addr   : byte address of the next read to issue
//   recv_addr    : byte address of the word currently being received
//   tx_done      : all words of the block have been issued
//   rx_last      : the response being received is the final word
module fill_addr_gen
  #(parameter int ADDR_W          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int CNT_W           = 3)
  (input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic              issue,
   input  logic              recv,
   output logic [ADDR_W-1:0] issue_addr,
   output logic [ADDR_W-1:0] recv_addr,
   output logic              tx_done,
   output logic              rx_last);

  // Byte-offset bits inside a block of 2-byte words.
  localparam logic [ADDR_W-1:0] OFFS_MASK = ADDR_W'(2 * WORDS_PER_BLOCK - 1);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(WORDS_PER_BLOCK - 1);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  // tx_cnt wraps back to 0 after the last issue, so a separate flag
  // remembers that the whole block has gone out.
  logic              tx_done_q, tx_done_d;

  always_comb begin
    base_d    = base_q;
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    tx_done_d = tx_done_q;
    if (start) begin
      base_d    = start_addr & ~OFFS_MASK;
      tx_cnt_d  = '0;
      rx_cnt_d  = '0;
      tx_done_d = 1'b0;
    end else begin
      if (issue) begin
        tx_cnt_d = tx_cnt_q + CNT_W'(1);
        if (tx_cnt_q == LAST_IDX) tx_done_d = 1'b1;
      end
      if (recv) rx_cnt_d = rx_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q    <= '0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      tx_done_q <= 1'b0;
    end else begin
      base_q    <= base_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign issue_addr = base_q + (ADDR_W'(tx_cnt_q) << 1);
  assign recv_addr  = base_q + (ADDR_W'(rx_cnt_q) << 1);
  assign tx_done    = tx_done_q;
  assign rx_last    = (rx_cnt_q == LAST_IDX);

endmodule

// File: rtl/mem_fill_arbiter.sv
// Main-memory port arbiter for the I-cache miss handler, the D-cache miss
// handler and D-stage write-through stores. Grants one requester at a time
// (store > D miss > I miss) and streams 8-word block fills through the
// pipelined, fixed-latency memory read path.
//
// Handshake: every request is a level held by its requester until the
// matching one-cycle pulse (d_wr_ack, d_fill_done, i_fill_done). Requests
// are only sampled in IDLE; the grant is registered.
//
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   i_miss_req/i_miss_addr      : I-cache miss request and byte address
//   d_miss_req/d_miss_addr      : D-cache miss request and byte address
//   d_wr_req/d_wr_addr/d_wr_data: write-through store request
//   mem_en/mem_wr/mem_addr/mem_wdata : memory command port
//   mem_rdata/mem_valid         : memory read response
//   fill_data/fill_addr         : fill word and its byte address
//   i_fill_we/d_fill_we         : fill word write strobes per cache
//   i_fill_done/d_fill_done     : one-cycle fill-complete pulses
//   d_wr_ack                    : one-cycle store-issued pulse
//   busy                        : arbiter is not IDLE
module mem_fill_arbiter
  import mem_arb_pkg::*;
  #(parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = mem_arb_pkg::WORDS_PER_BLOCK,
    parameter int CNT_W           = 3)
  (input  logic              clk,
   input  logic              rst_n,
   input  logic              i_miss_req,
   input  logic [ADDR_W-1:0] i_miss_addr,
   input  logic              d_miss_req,
   input  logic [ADDR_W-1:0] d_miss_addr,
   input  logic              d_wr_req,
   input  logic [ADDR_W-1:0] d_wr_addr,
   input  logic [DATA_W-1:0] d_wr_data,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_valid,
   output logic [DATA_W-1:0] fill_data,
   output logic [ADDR_W-1:0] fill_addr,
   output logic              i_fill_we,
   output logic              d_fill_we,
   output logic              i_fill_done,
   output logic              d_fill_done,
   output logic              d_wr_ack,
   output logic              busy);

  arb_state_t state_q, state_d;
  owner_t     owner_q, owner_d;

  logic              gen_start;
  logic [ADDR_W-1:0] gen_start_addr;
  logic              gen_issue;
  logic              gen_recv;
  logic [ADDR_W-1:0] issue_addr;
  logic [ADDR_W-1:0] recv_addr;
  logic              tx_done;
  logic              rx_last;

  fill_addr_gen #(
    .ADDR_W          (ADDR_W),
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
    .CNT_W           (CNT_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (gen_start),
    .start_addr (gen_start_addr),
    .issue      (gen_issue),
    .recv       (gen_recv),
    .issue_addr (issue_addr),
    .recv_addr  (recv_addr),
    .tx_done    (tx_done),
    .rx_last    (rx_last)
  );

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    gen_start      = 1'b0;
    gen_start_addr = '0;
    gen_issue      = 1'b0;
    gen_recv       = 1'b0;
    mem_en         = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    fill_data      = '0;
    fill_addr      = '0;
    i_fill_we      = 1'b0;
    d_fill_we      = 1'b0;
    i_fill_done    = 1'b0;
    d_fill_done    = 1'b0;
    d_wr_ack       = 1'b0;
    busy           = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (d_wr_req) begin
          state_d = WRITE;
        end else if (d_miss_req) begin
          state_d        = FILL;
          owner_d        = OWN_D;
          gen_start      = 1'b1;
          gen_start_addr = d_miss_addr;
        end else if (i_miss_req) begin
          state_d        = FILL;
          owner_d        = OWN_I;
          gen_start      = 1'b1;
          gen_start_addr = i_miss_addr;
        end
      end

      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_wr_addr;
        mem_wdata = d_wr_data;
        d_wr_ack  = 1'b1;
        state_d   = IDLE;
      end

      FILL: begin
        // Issue and receive run independently; they overlap once the
        // first response returns while later reads are still going out.
        if (!tx_done) begin
          mem_en    = 1'b1;
          mem_addr  = issue_addr;
          gen_issue = 1'b1;
        end
        if (mem_valid) begin
          gen_recv  = 1'b1;
          fill_data = mem_rdata;
          fill_addr = recv_addr;
          i_fill_we = (owner_q == OWN_I);
          d_fill_we = (owner_q == OWN_D);
          if (rx_last) state_d = DONE;
        end
      end

      DONE: begin
        i_fill_done = (owner_q == OWN_I);
        d_fill_done = (owner_q == OWN_D);
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
module tb_mem_fill_arbiter;
  import mem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        i_miss_req, d_miss_req, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        mem_en, mem_wr, mem_valid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] fill_data, fill_addr;
  logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, busy;
  logic        stray_valid;

  mem_fill_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_miss_req  (i_miss_req),
    .i_miss_addr (i_miss_addr),
    .d_miss_req  (d_miss_req),
    .d_miss_addr (d_miss_addr),
    .d_wr_req    (d_wr_req),
    .d_wr_addr   (d_wr_addr),
    .d_wr_data   (d_wr_data),
    .mem_en      (mem_en),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_valid   (mem_valid),
    .fill_data   (fill_data),
    .fill_addr   (fill_addr),
    .i_fill_we   (i_fill_we),
    .d_fill_we   (d_fill_we),
    .i_fill_done (i_fill_done),
    .d_fill_done (d_fill_done),
    .d_wr_ack    (d_wr_ack),
    .busy        (busy)
  );

  // ---------------- memory model: fixed-latency read pipe ----------------
  function automatic logic [15:0] mem_model(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC35A;
  endfunction

  logic [MEM_LATENCY-1:0] vpipe = '0;
  logic [15:0]            dpipe [MEM_LATENCY];

  always @(posedge clk) begin
    vpipe    <= {vpipe[MEM_LATENCY-2:0], mem_en & ~mem_wr};
    dpipe[0] <= mem_model(mem_addr);
    for (int i = 1; i < MEM_LATENCY; i++) dpipe[i] <= dpipe[i-1];
  end

  assign mem_valid = vpipe[MEM_LATENCY-1] | stray_valid;
  assign mem_rdata = dpipe[MEM_LATENCY-1];

  // ---------------- vector table ----------------
  typedef struct {
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic [15:0] d_addr;
    logic        w_req;
    logic [15:0] w_addr;
    logic [15:0] w_data;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        i_we;
    logic        d_we;
    logic [15:0] fill_addr;
    logic [15:0] fill_data;
    logic        i_done;
    logic        d_done;
    logic        ack;
    logic        busy;
  } vec_t;

  vec_t vecs[$];
  vec_t cur;  // current requester input levels while building the table

  function automatic vec_t base_row();
    vec_t v = '{default: '0};
    v.i_req  = cur.i_req;
    v.i_addr = cur.i_addr;
    v.d_req  = cur.d_req;
    v.d_addr = cur.d_addr;
    v.w_req  = cur.w_req;
    v.w_addr = cur.w_addr;
    v.w_data = cur.w_data;
    return v;
  endfunction

  function automatic void push_idle();
    vecs.push_back(base_row());
  endfunction

  function automatic void push_write(input logic [15:0] addr, input logic [15:0] data);
    vec_t v = base_row();
    v.mem_en    = 1'b1;
    v.mem_wr    = 1'b1;
    v.mem_addr  = addr;
    v.mem_wdata = data;
    v.ack       = 1'b1;
    v.busy      = 1'b1;
    vecs.push_back(v);
  endfunction

  // 13 busy cycles: reads in rows 0..7, responses in 4..11, done in 12.
  // drop_at: row at which the owning requester lowers its request.
  function automatic void push_fill(input bit is_d, input logic [15:0] base, input int drop_at);
    vec_t v;
    for (int k = 0; k < 13; k++) begin
      if (k == drop_at) begin
        if (is_d) cur.d_req = 1'b0;
        else      cur.i_req = 1'b0;
      end
      v = base_row();
      v.busy = 1'b1;
      if (k < 8) begin
        v.mem_en   = 1'b1;
        v.mem_addr = base + 16'(2 * k);
      end
      if (k >= 4 && k <= 11) begin
        if (is_d) v.d_we = 1'b1;
        else      v.i_we = 1'b1;
        v.fill_addr = base + 16'(2 * (k - 4));
        v.fill_data = mem_model(v.fill_addr);
      end
      if (k == 12) begin
        if (is_d) v.d_done = 1'b1;
        else      v.i_done = 1'b1;
      end
      vecs.push_back(v);
    end
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %0h, expected %0h", name, row, act, exp);
  endtask

  task automatic compare_row(input vec_t v, input int r);
    check("mem_en",      r, 32'(mem_en),      32'(v.mem_en));
    check("mem_wr",      r, 32'(mem_wr),      32'(v.mem_wr));
    check("i_fill_we",   r, 32'(i_fill_we),   32'(v.i_we));
    check("d_fill_we",   r, 32'(d_fill_we),   32'(v.d_we));
    check("i_fill_done", r, 32'(i_fill_done), 32'(v.i_done));
    check("d_fill_done", r, 32'(d_fill_done), 32'(v.d_done));
    check("d_wr_ack",    r, 32'(d_wr_ack),    32'(v.ack));
    check("busy",        r, 32'(busy),        32'(v.busy));
    if (v.mem_en) check("mem_addr", r, 32'(mem_addr), 32'(v.mem_addr));
    if (v.mem_wr) check("mem_wdata", r, 32'(mem_wdata), 32'(v.mem_wdata));
    if (v.i_we || v.d_we) begin
      check("fill_addr", r, 32'(fill_addr), 32'(v.fill_addr));
      check("fill_data", r, 32'(fill_data), 32'(v.fill_data));
    end
  endtask

  task automatic check_all_zero(input string name, input int r);
    logic [31:0] ored;
    ored = 32'({mem_en, mem_wr, i_fill_we, d_fill_we, i_fill_done,
                d_fill_done, d_wr_ack, busy});
    check({name, "_ctrl"},  r, ored, 32'h0);
    check({name, "_maddr"}, r, 32'(mem_addr),  32'h0);
    check({name, "_wdata"}, r, 32'(mem_wdata), 32'h0);
    check({name, "_faddr"}, r, 32'(fill_addr), 32'h0);
    check({name, "_fdata"}, r, 32'(fill_data), 32'h0);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    i_miss_req  = v.i_req;
    i_miss_addr = v.i_addr;
    d_miss_req  = v.d_req;
    d_miss_addr = v.d_addr;
    d_wr_req    = v.w_req;
    d_wr_addr   = v.w_addr;
    d_wr_data   = v.w_data;
  endtask

  // ---------------- test ----------------
  initial begin
    rst_n       = 1'b0;
    stray_valid = 1'b0;
    cur         = '{default: '0};
    drive(cur);

    // Table: I miss alone
    cur.i_req = 1'b1; cur.i_addr = 16'h0106;
    push_idle(); push_fill(1'b0, 16'h0100, 99);
    cur.i_req = 1'b0; push_idle();

    // Table: I and D miss together; D wins, then I
    cur.i_req = 1'b1; cur.i_addr = 16'h4008;
    cur.d_req = 1'b1; cur.d_addr = 16'h2004;
    push_idle(); push_fill(1'b1, 16'h2000, 99);
    cur.d_req = 1'b0; push_idle();
    push_fill(1'b0, 16'h4000, 99);
    cur.i_req = 1'b0; push_idle();

    // Table: store with an I miss pending
    cur.w_req = 1'b1; cur.w_addr = 16'h0040; cur.w_data = 16'hBEEF;
    cur.i_req = 1'b1; cur.i_addr = 16'h0106;
    push_idle(); push_write(16'h0040, 16'hBEEF);
    cur.w_req = 1'b0; push_idle();
    push_fill(1'b0, 16'h0100, 99);
    cur.i_req = 1'b0; push_idle();

    // Table: back-to-back D misses
    cur.d_req = 1'b1; cur.d_addr = 16'h3000;
    push_idle(); push_fill(1'b1, 16'h3000, 99);
    cur.d_addr = 16'h3010; push_idle();
    push_fill(1'b1, 16'h3010, 99);
    cur.d_req = 1'b0; push_idle();

    // Table: I request dropped mid-fill
    cur.i_req = 1'b1; cur.i_addr = 16'h050C;
    push_idle(); push_fill(1'b0, 16'h0500, 3);
    push_idle();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_all_zero("reset", 0);
    rst_n = 1'b1;

    // Apply table
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      compare_row(vecs[i], i);
    end

    // Reset asserted during the 5th fill cycle
    @(negedge clk);
    i_miss_req = 1'b1; i_miss_addr = 16'h0200;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      if (k == 2) check("rst_seq_mem_addr", k, 32'(mem_addr), 32'h0204);
      if (k == 4) begin
        check("rst_seq_first_we", k, 32'(i_fill_we), 32'h1);
        check("rst_seq_first_faddr", k, 32'(fill_addr), 32'h0200);
        rst_n      = 1'b0;
        i_miss_req = 1'b0;
      end
    end
    @(negedge clk); #1;
    check_all_zero("after_rst", 5);
    rst_n = 1'b1;

    // Stale responses plus injected stray valids must be ignored
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      stray_valid = (j == 5 || j == 6);
      #1;
      check("stray_i_we",   j, 32'(i_fill_we),   32'h0);
      check("stray_d_we",   j, 32'(d_fill_we),   32'h0);
      check("stray_i_done", j, 32'(i_fill_done), 32'h0);
      check("stray_d_done", j, 32'(d_fill_done), 32'h0);
      check("stray_busy",   j, 32'(busy),        32'h0);
    end
    stray_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_fill_arbiter.md
Name: mem_fill_arbiter

Overview:
- Arbitrates the single shared main-memory port between the I-cache miss handler, the D-cache miss handler and D-stage write-through stores.
- Sequences 8-word block fills into the requesting cache, using the pipelined memory read path with fixed 4-cycle latency.
- Sits between the fetch/memory stage caches and the unified main memory.
- The hazard unit holds the pipeline via `busy` and the per-requester done pulses.

Parameters:
- ADDR_W, 16, byte address width
- DATA_W, 16, word width
- WORDS_PER_BLOCK, 8, words per cache block; power of 2
- CNT_W, 3, log2(WORDS_PER_BLOCK)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- i_miss_req  in  1  I-cache miss; level, held until i_fill_done
- i_miss_addr  in  ADDR_W  I-cache miss byte address
- d_miss_req  in  1  D-cache miss; level, held until d_fill_done
- d_miss_addr  in  ADDR_W  D-cache miss byte address
- d_wr_req  in  1  write-through store; level, held until d_wr_ack
- d_wr_addr  in  ADDR_W  store byte address
- d_wr_data  in  DATA_W  store data
- mem_en  out  1  memory access strobe
- mem_wr  out  1  1=write, 0=read
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_valid  in  1  mem_rdata valid; arrives 4 cycles after the read's mem_en
- fill_data  out  DATA_W  fill word; shared by both caches
- fill_addr  out  ADDR_W  byte address of fill word
- i_fill_we  out  1  write fill word into I-cache
- d_fill_we  out  1  write fill word into D-cache
- i_fill_done  out  1  one-cycle pulse, I fill complete
- d_fill_done  out  1  one-cycle pulse, D fill complete
- d_wr_ack  out  1  one-cycle pulse, store issued
- busy  out  1  arbiter not IDLE

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; owner, tx_cnt, rx_cnt and base cleared.
  - All outputs 0.
  - Reset mid-fill or mid-write abandons the operation; no done/ack is issued.
- States: IDLE, WRITE, FILL, DONE.
- IDLE arbitration, sampled each posedge:
  - Fixed priority: d_wr_req > d_miss_req > i_miss_req.
  - Grant is registered, so the next cycle is the first WRITE/FILL cycle.
  - I can wait while D requests; this is acceptable because the D stage stalls while it waits.
- WRITE (exactly 1 cycle):
  - mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data, d_wr_ack=1.
  - Next state IDLE.
- FILL:
  - base = addr & ~(2*WORDS_PER_BLOCK-1), latched at grant (0x0106 -> 0x0100).
  - Issue side: while tx_cnt has not issued all words, mem_en=1, mem_wr=0, mem_addr=base+2*tx_cnt, tx_cnt++ each cycle. This gives 8 consecutive cycles with no bubbles.
  - Receive side: on mem_valid, the owner's fill_we=1, fill_data=mem_rdata, fill_addr=base+2*rx_cnt, rx_cnt++.
  - fill_we/data/addr are combinational from mem_valid.
  - The 8th mem_valid moves the block to DONE.
  - Requester inputs are ignored during FILL. Dropping a request mid-fill still completes the fill.
- DONE (1 cycle): owner's *_fill_done=1, then IDLE. The pending request is re-arbitrated on the next IDLE cycle.
- mem_valid outside FILL is ignored (stale responses after a reset).
- Latency: grant edge T; reads issue in cycles T..T+7; valids arrive in T+4..T+11; done at T+12. Total 13 cycles busy for a fill, 1 for a write.
- busy=1 in WRITE, FILL and DONE.
- Counters wrap mod WORDS_PER_BLOCK. Overflow is not possible because tx stops after 8 issues.

Decomposition:
- Package mem_arb_pkg:
  - state enum typedef arb_state_t {IDLE, WRITE, FILL, DONE}.
  - owner enum {OWN_I, OWN_D}.
  - Constants MEM_LATENCY=4, WORDS_PER_BLOCK=8.
- Sub-module fill_addr_gen holds base/tx_cnt/rx_cnt and produces the issue/receive addresses plus the last-word flags.
- The top holds the FSM and output muxing.

Test Plan:
- I miss at 0x0106 alone -> mem_addr 0x0100,0x0102..0x010E on 8 consecutive cycles; i_fill_we ×8 with matching fill_addr/data; i_fill_done exactly 13 cycles after the grant edge; d_fill_we never set.
- i_miss_req and d_miss_req (0x2004) raised in the same cycle -> D block 0x2000 fills first with d_fill_done, then I fill starts on the cycle after the return to IDLE.
- d_wr_req addr 0x0040 data 0xBEEF with i_miss_req pending -> one write cycle (mem_wr=1, d_wr_ack=1), then I fill.
- Reset asserted at the 5th fill cycle -> next cycle all outputs 0 and state IDLE. Subsequent stray mem_valid pulses produce no fill_we and no done.
- Back-to-back D misses 0x3000 then 0x3010 -> two fills separated by the DONE and IDLE cycles; second base is 0x3010.
- Requester drops i_miss_req mid-fill -> fill still completes and i_fill_done pulses.
